// File: rtl/q3_pkg.sv
// rtl/q3_pkg.sv - shared types and constants for the q3b sweep checker
// Contents: state_t (IDLE, SETTLE, DONE), VEC_W (stimulus vector width),
//           Q3B_EXPECTED (golden truth table, bit i = F for i={A,B,C,D}).
package q3_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DONE
   } state_t;

   localparam int VEC_W = 4;
   localparam logic [15:0] Q3B_EXPECTED = 16'h2435;

endpackage

// File: rtl/q3b_settle_timer.sv
// rtl/q3b_settle_timer.sv - loadable down-counter with zero flag
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       load load_val (takes priority over counting)
//   en         count down by one while cnt is nonzero
//   load_val   reload value
//   cnt        current count
//   zero       cnt == 0
module q3b_settle_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/q3b_sweep_checker.sv
// rtl/q3b_sweep_checker.sv - exhaustive 16-vector sweep and truth-table check of q3b
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   start, abort    begin a sweep (IDLE only) / cancel a sweep
//   f_in            function output under test, combinational from a..d
//   a, b, c, d      registered stimulus, a = MSB of the vector index
//   busy, done      sweep in progress / one-cycle completion pulse
//   pass            no mismatches in the last completed sweep
//   truth_table     observed F, bit i captured at vector i
//   fail_count      number of mismatching table bits (0..16)
//   first_fail_idx  lowest mismatching index, 0 if none
module q3b_sweep_checker
   import q3_pkg::*;
#(
   parameter int          SETTLE_CYCLES = 1,
   parameter logic [15:0] EXPECTED      = Q3B_EXPECTED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        f_in,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] truth_table,
   output logic [4:0]  fail_count,
   output logic [3:0]  first_fail_idx
);

   localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
   localparam logic [VEC_W-1:0] LAST_IDX = '1;

   state_t           state;
   logic [VEC_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic             start_ok;
   logic             sample;
   logic             mismatch;
   logic [4:0]       fail_next;
   logic             timer_load;

   // The index register doubles as the stimulus vector, so a..d always
   // show the vector currently being settled.
   assign {a, b, c, d} = idx;

   assign start_ok   = (state == IDLE) && start && !abort;
   assign sample     = (state == SETTLE) && cnt_zero && !abort;
   assign mismatch   = (f_in != EXPECTED[idx]);
   assign fail_next  = fail_count + {4'b0000, mismatch};
   // Reload on every new vector: at start, and on each sample except the last.
   assign timer_load = start_ok || (sample && (idx != LAST_IDX));

   q3b_settle_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .en       (state == SETTLE),
      .load_val (CNT_INIT),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         truth_table    <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state          <= SETTLE;
                  idx            <= '0;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  truth_table    <= '0;
                  fail_count     <= '0;
                  first_fail_idx <= '0;
               end
            end
            SETTLE: begin
               if (abort) begin
                  state          <= IDLE;
                  idx            <= '0;
                  busy           <= 1'b0;
                  pass           <= 1'b0;
                  truth_table    <= '0;
                  fail_count     <= '0;
                  first_fail_idx <= '0;
               end else if (cnt_zero) begin
                  truth_table[idx] <= f_in;
                  fail_count       <= fail_next;
                  if (mismatch && (fail_count == '0)) begin
                     first_fail_idx <= idx;
                  end
                  if (idx == LAST_IDX) begin
                     // pass is taken from the final count so it is valid
                     // in the same cycle as done.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (fail_next == '0);
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   logic unused_sample;
   assign unused_sample = sample;

endmodule
